brick_map_ctrl: RTL and testbench

- Owns the 64-entry brick hit-point map for the brick game and sequences it through level load, play and clear.
- Loads a level pattern from a level ROM one brick per cycle and tracks total remaining hit points.
- Arbitrates brick-hit requests from two ball collision units (round-robin) and serves a read port for the VGA renderer.
- Sits between the game FSM (drives load_start/level), the ball units, and the renderer.

---
 rtl/brick_pkg.sv | 43 ++++
 rtl/brick_level_rom.sv | 23 ++
 rtl/brick_map_ctrl.sv | 161 ++++++++++++++++
 tb/tb_brick_map_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// brick_pkg: shared constants, types and the level-0 brick pattern for the brick map controller.
// The score helper exists only when BRICK_SCORE_EN is defined.
package brick_pkg;

  localparam int N_BRICKS = 64;
  localparam int IDX_W    = 6;
  localparam int HP_W     = 2;
  localparam int CNT_W    = 8;
  localparam int LVL_W    = 3;

  typedef logic [HP_W-1:0] hp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PLAY  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Index = row*8 + col, row 0 first.
  localparam hp_t LEVEL0_MAP [N_BRICKS] = '{
    2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0,
    2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0,
    2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0,
    2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1,
    2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0
  };

`ifdef BRICK_SCORE_EN
  localparam int SCORE_W = 16;

  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s,
                                                   input logic [2:0] inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W-2){1'b0}}, inc};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/brick_level_rom.sv
// brick_level_rom: combinational level pattern lookup, hit points for (level, brick index).
// Level 0 is a fixed table, level 1 alternates rows of 1 and 2, higher levels are all 3.
module brick_level_rom
  import brick_pkg::*;
(
  input  logic [LVL_W-1:0] level,
  input  logic [IDX_W-1:0] idx,
  output hp_t              hp
);

  always_comb begin
    hp = '0;
    if (level == LVL_W'(0)) begin
      hp = LEVEL0_MAP[idx];
    end else if (level == LVL_W'(1)) begin
      // idx[3] is the low bit of the row number: odd rows carry 2 HP.
      hp = idx[3] ? HP_W'(2) : HP_W'(1);
    end else begin
      hp = HP_W'(3);
    end
  end

endmodule

// File: rtl/brick_map_ctrl.sv
// brick_map_ctrl: brick HP map owner - level loader, round-robin two-ball hit arbiter, renderer read port.
// Defining BRICK_SCORE_EN adds a saturating 16-bit score output.
//
// state | meaning
// IDLE  | no level loaded, hits ignored
// LOAD  | copying the selected level from ROM, one brick per cycle
// PLAY  | serving one ball hit per cycle
// CLEAR | every brick destroyed, waiting for the next load_start
module brick_map_ctrl
  import brick_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  input  logic             load_start,
  output logic             load_done,
  input  logic [1:0]       hit_req,
  input  logic [IDX_W-1:0] hit_idx0,
  input  logic [IDX_W-1:0] hit_idx1,
  output logic [1:0]       hit_ack,
  output logic             hit_destroyed,
  output logic             hit_miss,
  input  logic [IDX_W-1:0] rd_idx,
  output hp_t              rd_hp,
  output logic [CNT_W-1:0] hp_left,
  output logic             level_clear,
  output logic             busy
`ifdef BRICK_SCORE_EN
  ,
  output logic [SCORE_W-1:0] score
`endif
);

  state_t           state;
  state_t           state_nxt;
  hp_t              hp_map [N_BRICKS];
  logic [IDX_W-1:0] load_idx;
  logic [LVL_W-1:0] level_q;
  logic             rr_ptr;
  hp_t              rom_hp;

  logic             load_step;
  logic             load_last;
  logic [CNT_W-1:0] load_total;
  logic             hit_fire;
  logic             gnt_sel;
  logic [IDX_W-1:0] gnt_idx;
  hp_t              gnt_hp;
  logic             gnt_live;
  logic             clear_hit;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  hp_t              wr_val;

  brick_level_rom u_rom (
    .level (level_q),
    .idx   (load_idx),
    .hp    (rom_hp)
  );

  // A load_start cycle suppresses both the ROM write and any new grant.
  always_comb begin
    load_step  = (state == LOAD) && !load_start;
    load_last  = load_step && (load_idx == IDX_W'(N_BRICKS - 1));
    load_total = hp_left + CNT_W'(rom_hp);
    hit_fire   = (state == PLAY) && !load_start && (hit_req != 2'b00);
    gnt_sel    = (hit_req == 2'b11) ? rr_ptr : hit_req[1];
    gnt_idx    = gnt_sel ? hit_idx1 : hit_idx0;
    gnt_hp     = hp_map[gnt_idx];
    gnt_live   = hit_fire && (gnt_hp != '0);
    clear_hit  = gnt_live && (hp_left == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_last) state_nxt = (load_total == '0) ? CLEAR : PLAY;
        PLAY:    if (clear_hit) state_nxt = CLEAR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy   = (state == LOAD);
    wr_en  = load_step || gnt_live;
    wr_idx = load_step ? load_idx : gnt_idx;
    wr_val = load_step ? rom_hp : (gnt_hp - HP_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BRICKS; i++) hp_map[i] <= '0;
    end else if (wr_en) begin
      hp_map[wr_idx] <= wr_val;
    end
  end

  // Read port samples the map before this cycle's write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_hp <= '0;
    else      rd_hp <= hp_map[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_idx      <= '0;
      level_q       <= '0;
      hp_left       <= '0;
      rr_ptr        <= 1'b0;
      hit_ack       <= 2'b00;
      hit_destroyed <= 1'b0;
      hit_miss      <= 1'b0;
      load_done     <= 1'b0;
      level_clear   <= 1'b0;
    end else begin
      hit_ack       <= 2'b00;
      hit_destroyed <= 1'b0;
      hit_miss      <= 1'b0;
      load_done     <= load_last;
      level_clear   <= clear_hit;
      if (load_start) begin
        level_q  <= level;
        load_idx <= '0;
        hp_left  <= '0;
      end else if (load_step) begin
        load_idx <= load_idx + IDX_W'(1);
        hp_left  <= load_total;
      end else if (gnt_live) begin
        hp_left  <= hp_left - CNT_W'(1);
      end
      if (hit_fire) begin
        hit_ack       <= gnt_sel ? 2'b10 : 2'b01;
        hit_destroyed <= (gnt_hp == HP_W'(1));
        hit_miss      <= (gnt_hp == '0);
        rr_ptr        <= ~gnt_sel;
      end
    end
  end

`ifdef BRICK_SCORE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= '0;
    end else if (load_start) begin
      score <= '0;
    end else if (gnt_live) begin
      score <= score_add(score, (gnt_hp == HP_W'(1)) ? 3'd5 : 3'd1);
    end
  end
`endif

endmodule

// File: tb/tb_brick_map_ctrl.sv
// tb_brick_map_ctrl: table vectors, directed corner sequences and random hits against a reference model.
// Build with BRICK_SCORE_EN defined to also cover the score output.
module tb_brick_map_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] level = '0;
  logic       load_start = 1'b0;
  logic       load_done;
  logic [1:0] hit_req = '0;
  logic [5:0] hit_idx0 = '0;
  logic [5:0] hit_idx1 = '0;
  logic [1:0] hit_ack;
  logic       hit_destroyed;
  logic       hit_miss;
  logic [5:0] rd_idx = '0;
  logic [1:0] rd_hp;
  logic [7:0] hp_left;
  logic       level_clear;
  logic       busy;
`ifdef BRICK_SCORE_EN
  logic [15:0] score;
`endif

  brick_map_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .level         (level),
    .load_start    (load_start),
    .load_done     (load_done),
    .hit_req       (hit_req),
    .hit_idx0      (hit_idx0),
    .hit_idx1      (hit_idx1),
    .hit_ack       (hit_ack),
    .hit_destroyed (hit_destroyed),
    .hit_miss      (hit_miss),
    .rd_idx        (rd_idx),
    .rd_hp         (rd_hp),
    .hp_left       (hp_left),
    .level_clear   (level_clear),
    .busy          (busy)
`ifdef BRICK_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: brick map, remaining HP, arbiter preference, play phase.
  int mdl_hp [64];
  int mdl_left;
  int mdl_rr;
  bit mdl_play;
  int exp_ack, exp_d, exp_m, exp_lc, exp_rd;

  int l0_rows [8][8] = '{
    '{2,1,2,1,2,0,0,0}, '{1,2,1,2,0,1,0,0}, '{2,1,2,0,1,0,1,0}, '{0,1,0,2,0,2,0,1},
    '{0,0,1,0,1,0,1,0}, '{0,0,0,2,0,2,0,0}, '{0,0,0,0,1,0,0,0}, '{0,0,0,0,0,0,0,0}
  };

  typedef struct {
    logic [1:0] req;
    int         i0;
    int         i1;
    int         ack;
    int         d;
    int         m;
    int         left;
  } vec_t;

  vec_t vecs [11];

  function automatic int rom_val(int lv, int idx);
    if (lv == 0) return l0_rows[idx / 8][idx % 8];
    if (lv == 1) return ((idx / 8) % 2 == 0) ? 1 : 2;
    return 3;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl_hp[i] = 0;
    mdl_left = 0;
    mdl_rr   = 0;
    mdl_play = 0;
  endtask

  // Expected outputs for the coming edge, from the inputs currently driven.
  task automatic model_edge();
    int g, bi;
    exp_rd  = mdl_hp[rd_idx];
    exp_ack = 0; exp_d = 0; exp_m = 0; exp_lc = 0;
    if (mdl_play && hit_req != 2'b00) begin
      g       = (hit_req == 2'b11) ? mdl_rr : (hit_req[1] ? 1 : 0);
      mdl_rr  = 1 - g;
      bi      = (g == 1) ? int'(hit_idx1) : int'(hit_idx0);
      exp_ack = (g == 1) ? 2 : 1;
      if (mdl_hp[bi] == 0) begin
        exp_m = 1;
      end else begin
        mdl_hp[bi]--;
        mdl_left--;
        exp_d = (mdl_hp[bi] == 0) ? 1 : 0;
        if (mdl_left == 0) begin
          exp_lc   = 1;
          mdl_play = 0;
        end
      end
    end
  endtask

  task automatic drive(logic [1:0] req, int i0, int i1);
    hit_req  = req;
    hit_idx0 = 6'(i0);
    hit_idx1 = 6'(i1);
    model_edge();
    tick();
    hit_req = 2'b00;
  endtask

  task automatic do_reset();
    hit_req    = 2'b00;
    load_start = 1'b0;
    #2 rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic finish_load(int lv);
    int n, sum, acks;
    n = 0; acks = 0; sum = 0;
    while (busy && n < 200) begin
      n++;
      if (hit_ack != 2'b00) acks++;
      tick();
    end
    hit_req = 2'b00;
    for (int i = 0; i < 64; i++) begin
      mdl_hp[i] = rom_val(lv, i);
      sum += mdl_hp[i];
    end
    mdl_left = sum;
    mdl_play = (sum > 0);
    chk("load_cycles", n, 64);
    chk("acks_during_load", acks, 0);
    chk("load_done", int'(load_done), 1);
    chk("hp_left_loaded", int'(hp_left), sum);
    tick();
    chk("load_done_single", int'(load_done), 0);
  endtask

  task automatic load_level(int lv);
    level      = 3'(lv);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    finish_load(lv);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 0, 0,  1, 0, 0, 35};
    vecs[1]  = '{2'b01, 0, 0,  1, 1, 0, 34};
    vecs[2]  = '{2'b01, 0, 0,  1, 0, 1, 34};
    vecs[3]  = '{2'b10, 0, 1,  2, 1, 0, 33};
    vecs[4]  = '{2'b10, 0, 63, 2, 0, 1, 33};
    vecs[5]  = '{2'b11, 2, 3,  1, 0, 0, 32};
    vecs[6]  = '{2'b11, 2, 3,  2, 1, 0, 31};
    vecs[7]  = '{2'b11, 2, 3,  1, 1, 0, 30};
    vecs[8]  = '{2'b11, 2, 3,  2, 0, 1, 30};
    vecs[9]  = '{2'b00, 2, 3,  0, 0, 0, 30};
    vecs[10] = '{2'b10, 0, 11, 2, 0, 0, 29};

    // Reset values with a genuine falling edge on rst.
    #3 rst = 1'b0;
    #4;
    chk("rst_ack", int'(hit_ack), 0);
    chk("rst_destroyed", int'(hit_destroyed), 0);
    chk("rst_miss", int'(hit_miss), 0);
    chk("rst_load_done", int'(load_done), 0);
    chk("rst_level_clear", int'(level_clear), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hp_left", int'(hp_left), 0);
    chk("rst_rd_hp", int'(rd_hp), 0);
    tick();
    rst = 1'b1;
    tick();
    model_reset();

    // Hits in IDLE are ignored.
    drive(2'b11, 0, 1);
    chk("idle_ack", int'(hit_ack), 0);

    // Level 1 load and renderer reads.
    load_level(1);
    rd_idx = 6'd8;
    tick();
    chk("rd_hp_idx8", int'(rd_hp), 2);
    rd_idx = 6'd0;
    tick();
    chk("rd_hp_idx0", int'(rd_hp), 1);

    // Table vectors on level 0.
    do_reset();
    load_level(0);
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].req, vecs[v].i0, vecs[v].i1);
      chk($sformatf("vec%0d_ack", v), int'(hit_ack), vecs[v].ack);
      chk($sformatf("vec%0d_destroyed", v), int'(hit_destroyed), vecs[v].d);
      chk($sformatf("vec%0d_miss", v), int'(hit_miss), vecs[v].m);
      chk($sformatf("vec%0d_hp_left", v), int'(hp_left), vecs[v].left);
    end

    // Both requests held on level 2: round-robin alternation.
    do_reset();
    load_level(2);
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 5, 6);
      chk($sformatf("rr_ack%0d", c), int'(hit_ack), (c % 2 == 0) ? 1 : 2);
    end
    chk("rr_hp_left", int'(hp_left), 188);

    // Same brick from both balls: second request sees the updated HP.
    load_level(1);
    drive(2'b11, 32, 32);
    chk("same_first_ack", int'(hit_ack), 1);
    chk("same_first_destroyed", int'(hit_destroyed), 1);
    drive(2'b10, 0, 32);
    chk("same_second_ack", int'(hit_ack), 2);
    chk("same_second_miss", int'(hit_miss), 1);
    chk("same_second_destroyed", int'(hit_destroyed), 0);
    chk("same_hp_left", int'(hp_left), 95);

    // load_start in PLAY with a request pending: no grant, request held through LOAD.
    hit_req    = 2'b01;
    hit_idx0   = 6'd0;
    level      = 3'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("restart_no_ack", int'(hit_ack), 0);
    chk("restart_busy", int'(busy), 1);
    finish_load(0);

    // Clear level 0 completely.
    for (int i = 0; i < 64; i++) begin
      while (mdl_hp[i] > 0) begin
        drive(2'b01, i, 0);
        chk("clr_ack", int'(hit_ack), exp_ack);
        chk("clr_destroyed", int'(hit_destroyed), exp_d);
        chk("clr_level_clear", int'(level_clear), exp_lc);
        chk("clr_hp_left", int'(hp_left), mdl_left);
      end
    end
    chk("clr_final_hp_left", int'(hp_left), 0);
    chk("clr_final_pulse", int'(level_clear), 1);
    tick();
    chk("clr_pulse_single", int'(level_clear), 0);
    drive(2'b11, 0, 1);
    chk("clear_ignores_hit", int'(hit_ack), 0);
    drive(2'b01, 2, 0);
    chk("clear_ignores_hit2", int'(hit_ack), 0);
    load_level(0);

    // Restart mid-LOAD with a different level.
    level      = 3'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (30) tick();
    load_level(2);
    chk("restart_hp_left", int'(hp_left), 192);

    // Asynchronous reset while an ack is showing.
    drive(2'b01, 7, 0);
    chk("pre_rst_ack", int'(hit_ack), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_ack", int'(hit_ack), 0);
    chk("async_hp_left", int'(hp_left), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_destroyed", int'(hit_destroyed), 0);
    do_reset();
    rd_idx = 6'd7;
    tick();
    chk("async_map_cleared", int'(rd_hp), 0);
    drive(2'b01, 7, 0);
    chk("async_idle_no_ack", int'(hit_ack), 0);

    // Random traffic against the model, level 0 then level 1.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      load_level(pass);
      for (int c = 0; c < 500; c++) begin
        rd_idx = 6'($urandom_range(0, 63));
        drive(2'($urandom_range(0, 3)), $urandom_range(0, 63), $urandom_range(0, 63));
        chk("rnd_ack", int'(hit_ack), exp_ack);
        chk("rnd_destroyed", int'(hit_destroyed), exp_d);
        chk("rnd_miss", int'(hit_miss), exp_m);
        chk("rnd_level_clear", int'(level_clear), exp_lc);
        chk("rnd_hp_left", int'(hp_left), mdl_left);
        chk("rnd_rd_hp", int'(rd_hp), exp_rd);
      end
    end

`ifdef BRICK_SCORE_EN
    do_reset();
    chk("score_reset", int'(score), 0);
    load_level(0);
    drive(2'b01, 0, 0);
    chk("score_plain_hit", int'(score), 1);
    load_level(0);
    chk("score_cleared_on_load", int'(score), 0);
    drive(2'b01, 1, 0);
    chk("score_destroy", int'(score), 5);
    drive(2'b01, 1, 0);
    chk("score_miss_unchanged", int'(score), 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
